cam_ctrl: RTL and testbench

//  Command front-end and sequencer for the shift-register CAM (cam_srl).
//  - Accepts LOOKUP / INSERT / DELETE commands on a valid/ready channel.
//  - Allocates free entries, tracks occupancy and sequences compare, then write/delete.
//  - Honours the CAM's init and write-busy periods; returns one response per command.
//  - Sits between the SIMD scheduler and a single cam_srl instance.

---
 rtl/cam_ctrl_pkg.sv | 31 +++
 rtl/cam_ctrl_priority_encoder.sv | 39 +++
 rtl/cam_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_ctrl_pkg.sv
// Shared op/status codes and FSM state encoding for the CAM command sequencer.
package cam_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_MISS = 2'd1,
    ST_FULL = 2'd2,
    ST_DUP  = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_SAMPLE,
    S_WR,
    S_WBUSY,
    S_RSP
  } state_e;

  function automatic int slice_count(input int data_width, input int slice_width);
    return (data_width + slice_width - 1) / slice_width;
  endfunction

endpackage

// File: rtl/cam_ctrl_priority_encoder.sv
// Priority encoder over a one-hot-ish request vector; LSB_PRIORITY "HIGH" makes
// the lowest set index win. output_valid=0 when no bit is set.
module cam_ctrl_priority_encoder #(
  parameter int WIDTH        = 8,
  parameter     LSB_PRIORITY = "HIGH",
  localparam int EW          = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] input_unencoded,
  output logic             output_valid,
  output logic [EW-1:0]    output_encoded
);

  generate
    if (LSB_PRIORITY == "HIGH") begin : g_lsb_first
      always_comb begin
        output_valid   = 1'b0;
        output_encoded = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (input_unencoded[i]) begin
            output_valid   = 1'b1;
            output_encoded = i[EW-1:0];
          end
        end
      end
    end else begin : g_msb_first
      always_comb begin
        output_valid   = 1'b0;
        output_encoded = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (input_unencoded[i]) begin
            output_valid   = 1'b1;
            output_encoded = i[EW-1:0];
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cam_ctrl.sv
// Command front-end and sequencer for a single shift-register CAM.
// Optional build macro CAM_CTRL_DUP_CHECK_EN: INSERT compares first and reports DUP on a hit.
module cam_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int  DATA_WIDTH  = 64,
  parameter int  ADDR_WIDTH  = 5,
  parameter int  SLICE_WIDTH = 4,
  localparam int SLICE_COUNT = slice_count(DATA_WIDTH, SLICE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [DATA_WIDTH-1:0]  cmd_key,
  input  logic [SLICE_COUNT-1:0] cmd_mask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_status,
  output logic [ADDR_WIDTH-1:0]  rsp_addr,
  output logic [ADDR_WIDTH:0]    occupancy,
  output logic                   cam_rst,
  output logic [ADDR_WIDTH-1:0]  cam_write_addr,
  output logic [DATA_WIDTH-1:0]  cam_write_data,
  output logic                   cam_write_delete,
  output logic                   cam_write_enable,
  output logic [SLICE_COUNT-1:0] cam_write_select_mask,
  input  logic                   cam_write_busy,
  output logic [DATA_WIDTH-1:0]  cam_compare_data,
  input  logic                   cam_match,
  input  logic [ADDR_WIDTH-1:0]  cam_match_addr
);

  localparam int                 ENTRIES = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] OCC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] OCC_ONE = 1;

  logic [1:0]             rst_sync_q;
  state_e                 state_q;
  op_e                    op_q;
  logic [DATA_WIDTH-1:0]  key_q;
  logic [SLICE_COUNT-1:0] mask_q;
  logic [ENTRIES-1:0]     bitmap_q;
  logic [ADDR_WIDTH:0]    occ_q;
  logic                   seen_busy_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic                   wr_del_q;
  logic                   wr_en_q;
  logic                   rsp_valid_q;
  status_e                rsp_status_q;
  logic [ADDR_WIDTH-1:0]  rsp_addr_q;

  logic                   free_vld;
  logic [ADDR_WIDTH-1:0]  free_idx;
  logic                   hit;

  // cam_rst follows rst_n asynchronously on assertion, releases two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b11;
    else        rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  cam_ctrl_priority_encoder #(
    .WIDTH        (ENTRIES),
    .LSB_PRIORITY ("HIGH")
  ) u_free_enc (
    .input_unencoded (~bitmap_q),
    .output_valid    (free_vld),
    .output_encoded  (free_idx)
  );

  // A CAM match on an entry we never allocated is stale and counts as a miss.
  assign hit = cam_match && bitmap_q[cam_match_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_LOOKUP;
      key_q        <= '0;
      mask_q       <= '0;
      bitmap_q     <= '0;
      occ_q        <= '0;
      seen_busy_q  <= 1'b0;
      wr_addr_q    <= '0;
      wr_del_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_addr_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q   <= op_e'(cmd_op);
            key_q  <= cmd_key;
            mask_q <= cmd_mask;
`ifdef CAM_CTRL_DUP_CHECK_EN
            state_q <= S_CMP;
`else
            if (op_e'(cmd_op) == OP_INSERT) begin
              if (free_vld) begin
                wr_addr_q <= free_idx;
                wr_del_q  <= 1'b0;
                wr_en_q   <= 1'b1;
                state_q   <= S_WR;
              end else begin
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= ST_FULL;
                rsp_addr_q   <= '0;
                state_q      <= S_RSP;
              end
            end else begin
              state_q <= S_CMP;
            end
`endif
          end
        end
        S_CMP: state_q <= S_SAMPLE;
        S_SAMPLE: begin
          case (op_q)
            OP_INSERT: begin
              if (hit) begin
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= ST_DUP;
                rsp_addr_q   <= cam_match_addr;
                state_q      <= S_RSP;
              end else if (!free_vld) begin
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= ST_FULL;
                rsp_addr_q   <= '0;
                state_q      <= S_RSP;
              end else begin
                wr_addr_q <= free_idx;
                wr_del_q  <= 1'b0;
                wr_en_q   <= 1'b1;
                state_q   <= S_WR;
              end
            end
            OP_DELETE: begin
              if (hit) begin
                wr_addr_q <= cam_match_addr;
                wr_del_q  <= 1'b1;
                wr_en_q   <= 1'b1;
                state_q   <= S_WR;
              end else begin
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= ST_MISS;
                rsp_addr_q   <= '0;
                state_q      <= S_RSP;
              end
            end
            default: begin
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= hit ? ST_OK : ST_MISS;
              rsp_addr_q   <= hit ? cam_match_addr : '0;
              state_q      <= S_RSP;
            end
          endcase
        end
        S_WR: begin
          seen_busy_q <= 1'b0;
          state_q     <= S_WBUSY;
        end
        S_WBUSY: begin
          // The CAM may take a cycle to raise busy; only a fall after a rise means done.
          if (!seen_busy_q) begin
            if (cam_write_busy) seen_busy_q <= 1'b1;
          end else if (!cam_write_busy) begin
            if (wr_del_q) begin
              bitmap_q[wr_addr_q] <= 1'b0;
              if (occ_q != '0) occ_q <= occ_q - OCC_ONE;
            end else begin
              bitmap_q[wr_addr_q] <= 1'b1;
              if (occ_q != OCC_MAX) occ_q <= occ_q + OCC_ONE;
            end
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= ST_OK;
            rsp_addr_q   <= wr_addr_q;
            state_q      <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready             = (state_q == S_IDLE) && !cam_write_busy && !cam_rst;
  assign cam_rst               = rst_sync_q[1];
  assign rsp_valid             = rsp_valid_q;
  assign rsp_status            = rsp_status_q;
  assign rsp_addr              = rsp_addr_q;
  assign occupancy             = occ_q;
  assign cam_write_addr        = wr_addr_q;
  assign cam_write_data        = key_q;
  assign cam_write_delete      = wr_del_q;
  assign cam_write_enable      = wr_en_q;
  assign cam_write_select_mask = mask_q;
  assign cam_compare_data      = key_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl with a behavioural 8x16-bit shift-register CAM alongside;
// honours CAM_CTRL_DUP_CHECK_EN the same way the design does.
module tb_cam_ctrl;
  import cam_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_key = '0;
  logic [3:0]  cmd_mask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic [2:0]  rsp_addr;
  logic [3:0]  occupancy;
  logic        cam_rst;
  logic [2:0]  cam_write_addr;
  logic [15:0] cam_write_data;
  logic        cam_write_delete;
  logic        cam_write_enable;
  logic [3:0]  cam_write_select_mask;
  logic        cam_write_busy;
  logic [15:0] cam_compare_data;
  logic        cam_match;
  logic [2:0]  cam_match_addr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int we_cnt = 0;
  int txn = 0;

  cam_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .SLICE_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_addr(rsp_addr), .occupancy(occupancy), .cam_rst(cam_rst),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_write_select_mask(cam_write_select_mask), .cam_write_busy(cam_write_busy),
    .cam_compare_data(cam_compare_data), .cam_match(cam_match),
    .cam_match_addr(cam_match_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural CAM: 16-cycle busy sweep after reset and per write, registered match.
  logic [4:0]  m_cnt = '0;
  logic        m_busy = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_pdel = 1'b0;
  logic [2:0]  m_paddr = '0;
  logic [15:0] m_pdata = '0;
  logic [15:0] m_data [8];
  logic [7:0]  m_vld = '0;
  logic        m_match = 1'b0;
  logic [2:0]  m_maddr = '0;
  logic        m_hit;
  logic [2:0]  m_hit_addr;

  always_comb begin
    m_hit      = 1'b0;
    m_hit_addr = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m_vld[i] && m_data[i] == cam_compare_data) begin
        m_hit      = 1'b1;
        m_hit_addr = i[2:0];
      end
    end
  end

  always @(posedge clk) begin
    m_match <= m_hit;
    m_maddr <= m_hit_addr;
    if (cam_rst) begin
      m_cnt  <= 5'd16;
      m_busy <= 1'b1;
      m_pend <= 1'b0;
      m_vld  <= '0;
    end else if (m_cnt != 5'd0) begin
      m_cnt <= m_cnt - 5'd1;
      if (m_cnt == 5'd1) begin
        m_busy <= 1'b0;
        if (m_pend) begin
          m_pend <= 1'b0;
          if (m_pdel) m_vld[m_paddr] <= 1'b0;
          else begin
            m_vld[m_paddr]  <= 1'b1;
            m_data[m_paddr] <= m_pdata;
          end
        end
      end
    end else if (cam_write_enable) begin
      m_cnt   <= 5'd16;
      m_busy  <= 1'b1;
      m_pend  <= 1'b1;
      m_pdel  <= cam_write_delete;
      m_paddr <= cam_write_addr;
      m_pdata <= cam_write_data;
    end
  end

  assign cam_write_busy = m_busy;
  assign cam_match      = m_match;
  assign cam_match_addr = m_maddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: which keys occupy which entries.
  bit          ref_vld [8];
  logic [15:0] ref_key [8];

  function automatic int ref_find(input logic [15:0] key);
    for (int i = 0; i < 8; i++) if (ref_vld[i] && ref_key[i] == key) return i;
    return -1;
  endfunction

  function automatic int ref_free();
    for (int i = 0; i < 8; i++) if (!ref_vld[i]) return i;
    return -1;
  endfunction

  function automatic int ref_count();
    int c = 0;
    for (int i = 0; i < 8; i++) if (ref_vld[i]) c++;
    return c;
  endfunction

  // Expected CAM write, checked on every write_enable pulse.
  bit          exp_wr_valid = 1'b0;
  logic [2:0]  exp_wr_addr = '0;
  logic [15:0] exp_wr_key = '0;
  bit          exp_wr_del = 1'b0;
  logic [3:0]  exp_wr_mask = '0;

  initial forever begin
    @(negedge clk);
    if (rst_n && cam_write_enable) begin
      we_cnt++;
      chk("wr_expected", 32'(exp_wr_valid), 32'd1);
      chk("wr_addr", 32'(cam_write_addr), 32'(exp_wr_addr));
      chk("wr_data", 32'(cam_write_data), 32'(exp_wr_key));
      chk("wr_delete", 32'(cam_write_delete), 32'(exp_wr_del));
      chk("wr_mask", 32'(cam_write_select_mask), 32'(exp_wr_mask));
      exp_wr_valid = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] key, input logic [3:0] mask,
                       output bit ok);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_key   = key;
    cmd_mask  = mask;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_key    = 16'($urandom);
    cmd_mask   = 4'($urandom);
    cmd_op     = 2'($urandom);
    accept_cyc = cyc;
    ok = 1'b1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] key, input logic [3:0] mask,
                         input int rdelay);
    int idx;
    int n = 0;
    int we0;
    bit ok;
    bit do_wr = 1'b0;
    logic [1:0] est = ST_MISS;
    logic [2:0] eaddr = '0;
    case (op)
      2'd1: begin
        idx = -1;
`ifdef CAM_CTRL_DUP_CHECK_EN
        idx = ref_find(key);
`endif
        if (idx >= 0) begin
          est = ST_DUP; eaddr = 3'(idx);
        end else begin
          idx = ref_free();
          if (idx < 0) est = ST_FULL;
          else begin
            est = ST_OK; eaddr = 3'(idx); do_wr = 1'b1; exp_wr_del = 1'b0;
          end
        end
      end
      2'd2: begin
        idx = ref_find(key);
        if (idx >= 0) begin
          est = ST_OK; eaddr = 3'(idx); do_wr = 1'b1; exp_wr_del = 1'b1;
        end
      end
      default: begin
        idx = ref_find(key);
        if (idx >= 0) begin
          est = ST_OK; eaddr = 3'(idx);
        end
      end
    endcase
    exp_wr_valid = do_wr;
    exp_wr_addr  = eaddr;
    exp_wr_key   = key;
    exp_wr_mask  = mask;
    we0 = we_cnt;
    issue(op, key, mask, ok);
    if (!ok) return;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      chk($sformatf("rsp_timeout[%0d]", txn), 32'd0, 32'd1);
      return;
    end
    if (do_wr) begin
      ref_vld[eaddr] = (op == 2'd1);
      ref_key[eaddr] = key;
    end
    for (int k = 0; k < rdelay; k++) begin
      chk($sformatf("rsp_hold[%0d]", txn), {28'd0, rsp_valid, rsp_status, rsp_addr},
          {28'd0, 1'b1, est, eaddr});
      @(negedge clk);
    end
    chk($sformatf("rsp_status[%0d]", txn), 32'(rsp_status), 32'(est));
    chk($sformatf("rsp_addr[%0d]", txn), 32'(rsp_addr), 32'(eaddr));
    chk($sformatf("occupancy[%0d]", txn), 32'(occupancy), 32'(ref_count()));
    chk($sformatf("write_count[%0d]", txn), 32'(we_cnt - we0), 32'(do_wr));
    $display("txn %0d op=%0d key=%04h status=%0d addr=%0d occ=%0d", txn, op, key,
             rsp_status, rsp_addr, occupancy);
    txn++;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 8; i++) begin
      ref_vld[i] = 1'b0;
      ref_key[i] = '0;
    end
  endtask

  initial begin
    int rel_cyc;
    int fi;
    int n;
    int r;
    bit ok;
    clear_ref();
    repeat (3) @(negedge clk);
    chk("reset_cam_rst", 32'(cam_rst), 32'd1);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rsp", {29'd0, rsp_valid, rsp_status}, 32'd0);
    chk("reset_occ", 32'(occupancy), 32'd0);
    chk("reset_wr_en", 32'(cam_write_enable), 32'd0);
    rst_n = 1'b1;
    rel_cyc = cyc;
    @(negedge clk);
    chk("cam_rst_sync1", 32'(cam_rst), 32'd1);
    @(negedge clk);
    chk("cam_rst_release", 32'(cam_rst), 32'd0);

    // Directed sequence: first command waits out the init sweep.
    run_cmd(2'd0, 16'h1234, 4'hF, 0);
    chk("init_wait>=18", 32'((accept_cyc - rel_cyc) >= 18), 32'd1);
    run_cmd(2'd1, 16'h1234, 4'hF, 0);
    run_cmd(2'd0, 16'h1234, 4'hF, 0);
    run_cmd(2'd1, 16'h1234, 4'hF, 0);
    n = 0;
    while (ref_count() < 8) begin
      run_cmd(2'd1, 16'hA000 + 16'(n), 4'hF, 0);
      n++;
    end
    run_cmd(2'd1, 16'hBEEF, 4'hF, 0);
    run_cmd(2'd2, ref_key[3], 4'hF, 0);
    run_cmd(2'd1, 16'hAAAA, 4'hF, 0);
    run_cmd(2'd3, 16'hAAAA, 4'hF, 0);

    // Randomized traffic over a small key pool so hits, dups and full are common.
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      run_cmd((r < 4) ? 2'd1 : (r < 7) ? 2'd2 : (r < 9) ? 2'd0 : 2'd3,
              16'hC000 | 16'($urandom_range(0, 9)), 4'($urandom), $urandom_range(0, 3));
    end

    run_cmd(2'd0, 16'h1234, 4'hF, 10);

    // Reset in the middle of a write.
    fi = ref_free();
    if (fi < 0) begin
      run_cmd(2'd2, ref_key[0], 4'hF, 0);
      fi = ref_free();
    end
    exp_wr_valid = 1'b1;
    exp_wr_addr  = 3'(fi);
    exp_wr_key   = 16'h5A5A;
    exp_wr_del   = 1'b0;
    exp_wr_mask  = 4'hF;
    issue(2'd1, 16'h5A5A, 4'hF, ok);
    n = 0;
    while (!cam_write_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midwrite_busy_seen", 32'(cam_write_busy), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_occ", 32'(occupancy), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cam_rst", 32'(cam_rst), 32'd1);
    chk("midrst_wr_en", 32'(cam_write_enable), 32'd0);
    rst_n = 1'b1;
    exp_wr_valid = 1'b0;
    clear_ref();
    run_cmd(2'd0, 16'h5A5A, 4'hF, 0);
    run_cmd(2'd0, 16'h1234, 4'hF, 0);
    run_cmd(2'd1, 16'h0F0F, 4'hF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
